// File: rtl/grant_decoder.sv
// rtl/grant_decoder.sv - registered one-hot grant decoder with release, hold timeout and dead cycle
// Accepts an encoded index when idle and holds the grant until release or timeout.
module grant_decoder #(
  parameter int WIDTH    = 4,
  parameter int HOLD_MAX = 15,
  localparam int IW = $clog2(WIDTH),
  localparam int CW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IW-1:0]    in_encoded,
  input  logic [WIDTH-1:0] release_req,
  output logic [WIDTH-1:0] grant,
  output logic             grant_valid,
  output logic [IW-1:0]    grant_index,
  output logic             timeout,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic          accept, in_range, released, expired;

  assign accept   = in_valid && (state == IDLE);
  assign in_range = ({1'b0, in_encoded} < (IW+1)'(WIDTH));
  // Masking with grant honours only the current holder's release bit.
  assign released = |(release_req & grant);
  assign expired  = (HOLD_MAX != 0) && (cnt == CW'(HOLD_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && in_range) state_next = GRANT;
      GRANT:   if (released || expired) state_next = GAP;
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant       <= '0;
      grant_index <= '0;
      cnt         <= '0;
      timeout     <= 1'b0;
      err         <= 1'b0;
    end else begin
      timeout <= 1'b0;
      err     <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (in_range) begin
              grant       <= WIDTH'(1) << in_encoded;
              grant_index <= in_encoded;
              cnt         <= CW'(1);
            end else begin
              err <= 1'b1;
            end
          end
        end
        GRANT: begin
          if (released) begin
            grant <= '0;
          end else if (expired) begin
            grant   <= '0;
            timeout <= 1'b1;
          // With the timeout disabled the counter parks at its top value.
          end else if (cnt != '1) begin
            cnt <= cnt + CW'(1);
          end
        end
        default: grant <= '0;
      endcase
    end
  end

  always_comb begin
    in_ready    = (state == IDLE);
    grant_valid = |grant;
  end

endmodule

// File: tb/tb_grant_decoder.sv
// tb/tb_grant_decoder.sv - scoreboard bench for grant_decoder (WIDTH=4 model-checked, WIDTH=5 directed)
module tb_grant_decoder;

  localparam int HOLD = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [1:0] in_encoded;
  logic [3:0] release_req, grant;
  logic       grant_valid, timeout, err;
  logic [1:0] grant_index;

  logic       in_valid_b, in_ready_b;
  logic [2:0] in_encoded_b, grant_index_b;
  logic [4:0] release_b, grant_b;
  logic       grant_valid_b, timeout_b, err_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  grant_decoder #(.WIDTH(4), .HOLD_MAX(HOLD)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_encoded(in_encoded), .release_req(release_req), .grant(grant),
    .grant_valid(grant_valid), .grant_index(grant_index), .timeout(timeout), .err(err)
  );

  grant_decoder #(.WIDTH(5), .HOLD_MAX(HOLD)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_encoded(in_encoded_b), .release_req(release_b), .grant(grant_b),
    .grant_valid(grant_valid_b), .grant_index(grant_index_b), .timeout(timeout_b), .err(err_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] i;
    logic       to;
  } exp_t;
  exp_t sb[$];

  // Independent cycle model: 0=IDLE 1=GRANT 2=GAP
  int         m_state;
  logic [3:0] m_grant;
  logic [1:0] m_idx;
  int         m_cnt;
  logic [3:0] prev_grant;

  task automatic model_reset();
    m_state = 0; m_grant = '0; m_idx = '0; m_cnt = 0;
    sb.delete();
  endtask

  task automatic step(input logic v, input logic [1:0] e, input logic [3:0] r);
    exp_t x;
    in_valid = v; in_encoded = e; release_req = r;
    check("in_ready", in_ready, m_state == 0);
    x.to = 1'b0;
    case (m_state)
      0: if (v) begin m_grant = 4'b0001 << e; m_idx = e; m_cnt = 1; m_state = 1; end
      1: begin
        if ((r & m_grant) != 0) begin m_grant = '0; m_state = 2; end
        else if (m_cnt == HOLD) begin m_grant = '0; x.to = 1'b1; m_state = 2; end
        else m_cnt++;
      end
      default: m_state = 0;
    endcase
    x.g = m_grant; x.i = m_idx;
    sb.push_back(x);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      x = sb.pop_front();
      check("grant", grant, x.g);
      check("grant_index", grant_index, x.i);
      check("grant_valid", grant_valid, |x.g);
      check("timeout", timeout, x.to);
      check("err_a", err, 1'b0);
    end
    check("onehot", $countones(grant) <= 1, 1);
    if (grant != 0 && prev_grant != 0) check("gap", grant, prev_grant);
    prev_grant = grant;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] r;
    rst_n = 1'b0;
    in_valid = 0; in_encoded = 0; release_req = 0;
    in_valid_b = 0; in_encoded_b = 0; release_b = 0;
    prev_grant = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", grant, 4'b0);
    check("rst_grant_valid", grant_valid, 0);
    check("rst_index", grant_index, 0);
    check("rst_timeout", timeout, 0);
    check("rst_err", err, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;

    // Release path: transfer idx 2, hold 2 cycles, release, GAP, IDLE
    step(1, 2'd2, 4'b0000);
    check("rel_grant", grant, 4'b0100);
    step(0, 0, 4'b0000);
    step(0, 0, 4'b0000);
    step(0, 0, 4'b0100);
    check("rel_drop", grant, 4'b0000);
    check("rel_gap_ready", in_ready, 0);
    step(0, 0, 4'b0000);
    check("rel_ready", in_ready, 1);

    // Timeout: 15 granted cycles, then revoke
    step(1, 2'd1, 4'b0000);
    for (int i = 1; i < HOLD; i++) step(0, 0, 4'b0000);
    check("to_last_grant", grant, 4'b0010);
    step(0, 0, 4'b0000);
    check("to_pulse", timeout, 1);
    check("to_grant", grant, 4'b0000);
    step(0, 0, 4'b0000);
    check("to_pulse_once", timeout, 0);
    check("to_ready", in_ready, 1);

    // Foreign release ignored; holder release on last allowed cycle beats timeout
    step(1, 2'd3, 4'b0000);
    for (int i = 1; i < HOLD; i++) step(0, 0, 4'b0001);
    check("fr_hold", grant, 4'b1000);
    step(0, 0, 4'b1000);
    check("fr_timeout", timeout, 0);
    check("fr_grant", grant, 4'b0000);
    step(0, 0, 4'b0000);

    // Busy input ignored, then async reset mid-grant
    step(1, 2'd0, 4'b0000);
    step(1, 2'd3, 4'b0000);
    check("busy_grant", grant, 4'b0001);
    in_valid = 0;
    #3 rst_n = 1'b0;
    #1;
    check("arst_grant", grant, 4'b0000);
    check("arst_ready", in_ready, 1);
    check("arst_valid", grant_valid, 0);
    model_reset();
    prev_grant = '0;
    @(posedge clk); #1;
    check("arst_hold", grant, 4'b0000);
    rst_n = 1'b1;
    step(1, 2'd3, 4'b0000);
    check("arst_regrant", grant, 4'b1000);
    step(0, 0, 4'b1000);
    step(0, 0, 4'b0000);

    // WIDTH=5: out-of-range index errors, next index is accepted back-to-back
    in_valid_b = 1; in_encoded_b = 3'd6;
    @(posedge clk); #1;
    check("b_err", err_b, 1);
    check("b_err_grant", grant_b, 5'b0);
    check("b_err_ready", in_ready_b, 1);
    in_encoded_b = 3'd4;
    @(posedge clk); #1;
    in_valid_b = 0;
    check("b_err_once", err_b, 0);
    check("b_grant", grant_b, 5'b10000);
    check("b_index", grant_index_b, 3'd4);
    release_b = 5'b10000;
    @(posedge clk); #1;
    release_b = 0;
    check("b_release", grant_b, 5'b0);
    check("b_timeout", timeout_b, 0);

    // Random soak against the model
    for (int n = 0; n < 1000; n++) begin
      r = 4'($urandom);
      if ($urandom_range(0, 9) != 0) r = r & ~m_grant;
      step(1'($urandom), 2'($urandom), r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // No grant may be visible while reset is asserted
  always @(negedge clk) begin
    if (!rst_n) check("grant_in_reset", {grant_b, grant}, 9'b0);
  end

endmodule
